// File: rtl/cla_pkg.sv
// Shared constants and parameter helpers for the pipelined carry-lookahead adder/subtractor.
`timescale 1ns/1ps
package cla_pkg;

  localparam int CLA_GROUP_DEFAULT = 4;

  function automatic bit cla_params_ok(input int width, input int group, input int stages);
    return (stages >= 1) && (group >= 1) && (width >= 1) && ((width % (group * stages)) == 0);
  endfunction

  // Returns 1 for illegal parameter sets so the divide never faults before the check fires.
  function automatic int cla_gps(input int width, input int group, input int stages);
    if (!cla_params_ok(width, group, stages)) return 1;
    return width / (group * stages);
  endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit flat carry-lookahead group: sum bits plus group generate/propagate.
`timescale 1ns/1ps
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] beff,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             grp_g,
  output logic             grp_p
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             term;

  assign g = a & beff;
  assign p = a ^ beff;

  // Every carry is a sum of products straight from g/p/cin, so no bit waits on its neighbour.
  always_comb begin
    c     = '0;
    grp_g = 1'b0;
    term  = 1'b0;
    c[0]  = cin;
    for (int i = 1; i <= GROUP; i++) begin
      term = cin;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        c[i] = c[i] | term;
      end
    end
    for (int j = 0; j < GROUP; j++) begin
      term = g[j];
      for (int k = j + 1; k < GROUP; k++) term = term & p[k];
      grp_g = grp_g | term;
    end
  end

  assign grp_p = &p;
  assign sum   = p ^ c[GROUP-1:0];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices, each resolving its groups'
// carries combinationally and registering the slice carry, with valid/ready flow control.
`timescale 1ns/1ps
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = CLA_GROUP_DEFAULT,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Car,
  output logic             Ovf,
  output logic             Zero
);

  localparam int GPS = cla_gps(WIDTH, GROUP, STAGES);
  localparam int SW  = GPS * GROUP;

  generate
    if (!cla_params_ok(WIDTH, GROUP, STAGES)) begin : g_bad_params
      $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP*STAGES and STAGES >= 1");
    end
  endgenerate

  // Stage k holds operands waiting for slice k, the sum bits finished so far and the carry into slice k.
  logic [STAGES-1:0] v_q, v_d;
  logic [WIDTH-1:0]  a_q    [STAGES];
  logic [WIDTH-1:0]  a_d    [STAGES];
  logic [WIDTH-1:0]  beff_q [STAGES];
  logic [WIDTH-1:0]  beff_d [STAGES];
  logic [WIDTH-1:0]  sum_q  [STAGES];
  logic [WIDTH-1:0]  sum_d  [STAGES];
  logic [STAGES-1:0] c_q, c_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_out_q, sum_out_d;
  logic             car_q, car_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [SW-1:0]    slice_sum  [STAGES];
  logic             slice_cout [STAGES];
  logic [WIDTH-1:0] merged     [STAGES];
  logic             adv;

  genvar gi, gj;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slice
      logic [GPS-1:0] grp_g;
      logic [GPS-1:0] grp_p;
      logic [GPS:0]   grp_c;
      logic [SW-1:0]  s_sum;
      logic           term;

      // Group carries come from group G/P in one lookahead level, not rippled group to group.
      always_comb begin
        grp_c    = '0;
        term     = 1'b0;
        grp_c[0] = c_q[gi];
        for (int i = 1; i <= GPS; i++) begin
          term = c_q[gi];
          for (int j = 0; j < i; j++) term = term & grp_p[j];
          grp_c[i] = term;
          for (int j = 0; j < i; j++) begin
            term = grp_g[j];
            for (int k = j + 1; k < i; k++) term = term & grp_p[k];
            grp_c[i] = grp_c[i] | term;
          end
        end
      end

      for (gj = 0; gj < GPS; gj++) begin : g_group
        cla_group #(.GROUP(GROUP)) u_group (
          .a     (a_q[gi][gi*SW + gj*GROUP +: GROUP]),
          .beff  (beff_q[gi][gi*SW + gj*GROUP +: GROUP]),
          .cin   (grp_c[gj]),
          .sum   (s_sum[gj*GROUP +: GROUP]),
          .grp_g (grp_g[gj]),
          .grp_p (grp_p[gj])
        );
      end

      assign slice_sum[gi]  = s_sum;
      assign slice_cout[gi] = grp_c[GPS];
    end
  endgenerate

  assign adv = !out_valid_q || out_ready;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_d[k]    = v_q[k];
      a_d[k]    = a_q[k];
      beff_d[k] = beff_q[k];
      sum_d[k]  = sum_q[k];
      c_d[k]    = c_q[k];
      merged[k] = sum_q[k];
      merged[k][k*SW +: SW] = slice_sum[k];
    end
    out_valid_d = out_valid_q;
    sum_out_d   = sum_out_q;
    car_d       = car_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;

    // A stalled consumer freezes every stage; bubbles stay where they are.
    if (adv) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        a_d[0]    = A;
        beff_d[0] = B ^ {WIDTH{Sub}};
        c_d[0]    = Cin ^ Sub;
        sum_d[0]  = '0;
      end
      for (int k = 1; k < STAGES; k++) begin
        v_d[k]    = v_q[k-1];
        a_d[k]    = a_q[k-1];
        beff_d[k] = beff_q[k-1];
        sum_d[k]  = merged[k-1];
        c_d[k]    = slice_cout[k-1];
      end
      out_valid_d = v_q[STAGES-1];
      if (v_q[STAGES-1]) begin
        sum_out_d = merged[STAGES-1];
        car_d     = slice_cout[STAGES-1];
        ovf_d     = (a_q[STAGES-1][WIDTH-1] == beff_q[STAGES-1][WIDTH-1]) &&
                    (merged[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
        zero_d    = (merged[STAGES-1] == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      c_q         <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]    <= '0;
        beff_q[k] <= '0;
        sum_q[k]  <= '0;
      end
      out_valid_q <= 1'b0;
      sum_out_q   <= '0;
      car_q       <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      v_q         <= v_d;
      c_q         <= c_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]    <= a_d[k];
        beff_q[k] <= beff_d[k];
        sum_q[k]  <= sum_d[k];
      end
      out_valid_q <= out_valid_d;
      sum_out_q   <= sum_out_d;
      car_q       <= car_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign Sum       = sum_out_q;
  assign Car       = car_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

endmodule
